// File: rtl/load_store_unit.sv
// Load/store unit between execute and data memory: one request at a time, aligned accesses in one
// memory cycle, misaligned accesses split into byte accesses, sign/zero-extended load results.
module load_store_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  resp_valid_o,
  output logic                  resp_err_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  mem_we_o,
  output logic [2:0]            mem_funct3_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [1:0]            r_cnt;
  logic                  r_misal;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_asm;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_accept;
  logic                  w_reqLegal;
  logic                  w_reqMisal;
  logic                  w_reqErr;
  logic [1:0]            w_sizeM1;
  logic                  w_lastBeat;
  logic [DATA_WIDTH-1:0] w_accAddr;
  logic [7:0]            w_laneByte;
  logic [7:0]            w_storeByte;
  logic [DATA_WIDTH-1:0] w_asmNext;
  logic [DATA_WIDTH-1:0] w_raw;
  logic [DATA_WIDTH-1:0] w_loadResult;

  assign w_accept = req_valid_i && req_ready_o;

  // Request decode: legality by direction, alignment by access size
  always_comb begin
    w_reqLegal = 1'b0;
    w_reqMisal = 1'b0;
    if (req_we_i) begin
      w_reqLegal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
    end else begin
      w_reqLegal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                   (funct3_i == 3'b100) || (funct3_i == 3'b101);
    end
    case (funct3_i[1:0])
      2'b01:   w_reqMisal = addr_i[0];
      2'b10:   w_reqMisal = (addr_i[1:0] != 2'b00);
      default: w_reqMisal = 1'b0;
    endcase
    w_reqErr = !w_reqLegal || (w_reqMisal && !MISALIGN_EN);
  end

  always_comb begin
    case (r_funct3[1:0])
      2'b01:   w_sizeM1 = 2'd1;
      2'b10:   w_sizeM1 = 2'd3;
      default: w_sizeM1 = 2'd0;
    endcase
    w_lastBeat = !r_misal || (r_cnt == w_sizeM1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = w_reqErr ? RESP : ACCESS;
      ACCESS:  if (w_lastBeat) w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Misaligned beats walk a byte pointer with 32-bit wrap; aligned beats use the request as is
  always_comb begin
    w_accAddr = r_misal ? (r_addr + {{(DATA_WIDTH-2){1'b0}}, r_cnt}) : r_addr;
    case (w_accAddr[1:0])
      2'd0:    w_laneByte = mem_rdata_i[7:0];
      2'd1:    w_laneByte = mem_rdata_i[15:8];
      2'd2:    w_laneByte = mem_rdata_i[23:16];
      default: w_laneByte = mem_rdata_i[31:24];
    endcase
    case (r_cnt)
      2'd0:    w_storeByte = r_wdata[7:0];
      2'd1:    w_storeByte = r_wdata[15:8];
      2'd2:    w_storeByte = r_wdata[23:16];
      default: w_storeByte = r_wdata[31:24];
    endcase
    case (r_cnt)
      2'd0:    w_asmNext = r_asm | {24'b0, w_laneByte};
      2'd1:    w_asmNext = r_asm | {16'b0, w_laneByte, 8'b0};
      2'd2:    w_asmNext = r_asm | {8'b0, w_laneByte, 16'b0};
      default: w_asmNext = r_asm | {w_laneByte, 24'b0};
    endcase
  end

  always_comb begin
    if (r_misal) begin
      w_raw = w_asmNext;
    end else begin
      case (r_funct3[1:0])
        2'b00:   w_raw = {24'b0, w_laneByte};
        2'b01:   w_raw = r_addr[1] ? {16'b0, mem_rdata_i[31:16]} : {16'b0, mem_rdata_i[15:0]};
        default: w_raw = mem_rdata_i;
      endcase
    end
    case (r_funct3)
      3'b000:  w_loadResult = {{24{w_raw[7]}}, w_raw[7:0]};
      3'b001:  w_loadResult = {{16{w_raw[15]}}, w_raw[15:0]};
      3'b100:  w_loadResult = {24'b0, w_raw[7:0]};
      3'b101:  w_loadResult = {16'b0, w_raw[15:0]};
      default: w_loadResult = w_raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= 2'd0;
      r_misal  <= 1'b0;
      r_err    <= 1'b0;
      r_asm    <= '0;
      r_rdata  <= '0;
    end else if (w_accept) begin
      r_we     <= req_we_i;
      r_funct3 <= funct3_i;
      r_addr   <= addr_i;
      r_wdata  <= wdata_i;
      r_cnt    <= 2'd0;
      r_misal  <= w_reqMisal && !w_reqErr;
      r_err    <= w_reqErr;
      r_asm    <= '0;
      r_rdata  <= '0;
    end else if (r_state == ACCESS) begin
      r_cnt <= r_cnt + 2'd1;
      r_asm <= w_asmNext;
      if (w_lastBeat && !r_we) begin
        r_rdata <= w_loadResult;
      end
    end
  end

  // Everything is gated by rst so a reset cycle never writes memory or pulses a response
  always_comb begin
    req_ready_o  = (r_state == IDLE) && !rst;
    resp_valid_o = (r_state == RESP) && !rst;
    resp_err_o   = resp_valid_o && r_err;
    resp_rdata_o = resp_valid_o ? r_rdata : '0;
    mem_we_o     = 1'b0;
    mem_funct3_o = 3'b000;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if ((r_state == ACCESS) && !rst) begin
      mem_we_o     = r_we;
      mem_funct3_o = r_misal ? 3'b000 : r_funct3;
      mem_addr_o   = w_accAddr;
      if (r_misal) begin
        mem_wdata_o = {4{w_storeByte}};
      end else begin
        case (r_funct3[1:0])
          2'b00:   mem_wdata_o = {4{r_wdata[7:0]}};
          2'b01:   mem_wdata_o = {2{r_wdata[15:0]}};
          default: mem_wdata_o = r_wdata;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-addressed memory model on the main instance plus a
// MISALIGN_EN=0 instance for the error path.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        reqValid, reqReady, reqWe, respValid, respErr, memWe;
  logic [2:0]  funct3, memFunct3;
  logic [31:0] addr, wdata, respRdata, memAddr, memWdata, memRdata;

  logic        reqValid0, reqReady0, reqWe0, respValid0, respErr0, memWe0;
  logic [2:0]  funct30, memFunct30;
  logic [31:0] addr0, wdata0, respRdata0, memAddr0, memWdata0;

  load_store_unit #(.DATA_WIDTH(32), .MISALIGN_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_we_i(reqWe), .funct3_i(funct3),
    .addr_i(addr), .wdata_i(wdata),
    .resp_valid_o(respValid), .resp_err_o(respErr), .resp_rdata_o(respRdata),
    .mem_we_o(memWe), .mem_funct3_o(memFunct3), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
    .mem_rdata_i(memRdata)
  );

  load_store_unit #(.DATA_WIDTH(32), .MISALIGN_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid_i(reqValid0), .req_ready_o(reqReady0), .req_we_i(reqWe0), .funct3_i(funct30),
    .addr_i(addr0), .wdata_i(wdata0),
    .resp_valid_o(respValid0), .resp_err_o(respErr0), .resp_rdata_o(respRdata0),
    .mem_we_o(memWe0), .mem_funct3_o(memFunct30), .mem_addr_o(memAddr0), .mem_wdata_o(memWdata0),
    .mem_rdata_i(32'hCAFEF00D)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [logic [31:0]];
  int memVersion = 0;
  int writeCount = 0;
  int writeCount0 = 0;

  function automatic logic [7:0] rdByte(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] readWord(input logic [31:0] a);
    logic [31:0] base;
    base = {a[31:2], 2'b00};
    return {rdByte(base + 32'd3), rdByte(base + 32'd2), rdByte(base + 32'd1), rdByte(base)};
  endfunction

  always @(memAddr, memVersion) memRdata = readWord(memAddr);

  always @(posedge clk) begin
    if (memWe) begin
      case (memFunct3)
        3'b000: mem[memAddr] = memWdata[8*memAddr[1:0] +: 8];
        3'b001: begin
          mem[{memAddr[31:1], 1'b0}]        = memWdata[16*memAddr[1] +: 8];
          mem[{memAddr[31:1], 1'b0} + 32'd1] = memWdata[16*memAddr[1] + 8 +: 8];
        end
        default: begin
          for (int b = 0; b < 4; b++) mem[{memAddr[31:2], 2'b00} + 32'(b)] = memWdata[8*b +: 8];
        end
      endcase
      writeCount++;
      memVersion++;
    end
    if (memWe0) writeCount0++;
  end

  int          respLat;
  logic        gotErr;
  logic [31:0] gotData;
  logic [31:0] accAddr [0:15];
  logic [31:0] accWdata [0:15];
  logic [2:0]  accF3 [0:15];
  logic        accWe [0:15];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit sel, input logic we, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] d);
    int guard;
    bit found;
    @(negedge clk);
    if (sel) begin
      reqWe0 = we; funct30 = f3; addr0 = a; wdata0 = d; reqValid0 = 1'b1;
    end else begin
      reqWe = we; funct3 = f3; addr = a; wdata = d; reqValid = 1'b1;
    end
    guard = 0;
    while (!(sel ? reqReady0 : reqReady) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!(sel ? reqReady0 : reqReady)) begin
      checks++;
      errors++;
      $error("[TB] FAIL ready_timeout: observed 0 expected 1");
    end
    @(negedge clk);
    reqValid = 1'b0;
    reqValid0 = 1'b0;
    respLat = 1;
    found = 1'b0;
    gotErr = 1'b0;
    gotData = '0;
    while (!found && respLat <= 12) begin
      accAddr[respLat]  = sel ? memAddr0 : memAddr;
      accWdata[respLat] = sel ? memWdata0 : memWdata;
      accF3[respLat]    = sel ? memFunct30 : memFunct3;
      accWe[respLat]    = sel ? memWe0 : memWe;
      if (sel ? respValid0 : respValid) begin
        found = 1'b1;
        gotErr = sel ? respErr0 : respErr;
        gotData = sel ? respRdata0 : respRdata;
      end else begin
        @(negedge clk);
        respLat++;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $error("[TB] FAIL resp_timeout: observed no response expected a response");
    end
  endtask

  initial begin
    int wc;
    int pulses;
    rst = 1'b1;
    reqValid = 1'b0; reqWe = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    reqValid0 = 1'b0; reqWe0 = 1'b0; funct30 = 3'b000; addr0 = '0; wdata0 = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", {31'b0, reqReady}, 32'd0);
    checkOutput("reset_resp_valid", {31'b0, respValid}, 32'd0);
    checkOutput("reset_mem_we", {31'b0, memWe}, 32'd0);
    checkOutput("reset_mem_addr", memAddr, 32'd0);
    checkOutput("reset_rdata", respRdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", {31'b0, reqReady}, 32'd1);

    // Aligned word store then load
    applyStimulus(0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    checkOutput("sw_lat", respLat, 32'd2);
    checkOutput("sw_writes", writeCount, 32'd1);
    checkOutput("sw_funct3", {29'b0, accF3[1]}, 32'd2);
    checkOutput("sw_rdata", gotData, 32'd0);
    applyStimulus(0, 1'b0, 3'b010, 32'h100, 32'h0);
    checkOutput("lw_lat", respLat, 32'd2);
    checkOutput("lw_data", gotData, 32'hDEADBEEF);
    checkOutput("lw_err", {31'b0, gotErr}, 32'd0);

    // Aligned byte/half extraction and extension
    applyStimulus(0, 1'b1, 3'b010, 32'h100, 32'h80FF7F01);
    applyStimulus(0, 1'b0, 3'b000, 32'h101, 32'h0);
    checkOutput("lb_101", gotData, 32'h0000007F);
    applyStimulus(0, 1'b0, 3'b000, 32'h103, 32'h0);
    checkOutput("lb_103", gotData, 32'hFFFFFF80);
    applyStimulus(0, 1'b0, 3'b101, 32'h102, 32'h0);
    checkOutput("lhu_102", gotData, 32'h000080FF);
    applyStimulus(0, 1'b0, 3'b001, 32'h102, 32'h0);
    checkOutput("lh_102", gotData, 32'hFFFF80FF);
    applyStimulus(0, 1'b0, 3'b100, 32'h103, 32'h0);
    checkOutput("lbu_103", gotData, 32'h00000080);
    applyStimulus(0, 1'b1, 3'b001, 32'h202, 32'h00001234);
    checkOutput("sh_replicate", accWdata[1], 32'h12341234);

    // Misaligned word store split into bytes
    wc = writeCount;
    applyStimulus(0, 1'b1, 3'b010, 32'h101, 32'h11223344);
    checkOutput("msw_lat", respLat, 32'd5);
    checkOutput("msw_writes", writeCount - wc, 32'd4);
    checkOutput("msw_addr0", accAddr[1], 32'h101);
    checkOutput("msw_addr3", accAddr[4], 32'h104);
    checkOutput("msw_f3", {29'b0, accF3[4]}, 32'd0);
    checkOutput("msw_wdata1", accWdata[2], 32'h33333333);
    checkOutput("msw_byte104", {24'b0, rdByte(32'h104)}, 32'h11);
    applyStimulus(0, 1'b0, 3'b010, 32'h101, 32'h0);
    checkOutput("mlw_lat", respLat, 32'd5);
    checkOutput("mlw_data", gotData, 32'h11223344);
    applyStimulus(0, 1'b0, 3'b010, 32'h100, 32'h0);
    checkOutput("lw_100_merged", gotData, 32'h22334401);
    applyStimulus(0, 1'b1, 3'b001, 32'h103, 32'h0000A5B6);
    checkOutput("msh_lat", respLat, 32'd3);
    applyStimulus(0, 1'b0, 3'b101, 32'h103, 32'h0);
    checkOutput("mlhu_data", gotData, 32'h0000A5B6);
    applyStimulus(0, 1'b0, 3'b001, 32'h103, 32'h0);
    checkOutput("mlh_data", gotData, 32'hFFFFA5B6);

    // Halfword load across the top of the address space
    applyStimulus(0, 1'b1, 3'b000, 32'hFFFFFFFF, 32'h00000080);
    checkOutput("sb_replicate", accWdata[1], 32'h80808080);
    applyStimulus(0, 1'b1, 3'b000, 32'h00000000, 32'h000000C3);
    applyStimulus(0, 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
    checkOutput("wrap_lat", respLat, 32'd3);
    checkOutput("wrap_addr0", accAddr[1], 32'hFFFFFFFF);
    checkOutput("wrap_addr1", accAddr[2], 32'h00000000);
    checkOutput("wrap_data", gotData, 32'hFFFFC380);

    // Error responses
    wc = writeCount;
    applyStimulus(0, 1'b1, 3'b100, 32'h200, 32'h55555555);
    checkOutput("bad_store_lat", respLat, 32'd1);
    checkOutput("bad_store_err", {31'b0, gotErr}, 32'd1);
    checkOutput("bad_store_writes", writeCount - wc, 32'd0);
    applyStimulus(0, 1'b0, 3'b011, 32'h200, 32'h0);
    checkOutput("bad_load_err", {31'b0, gotErr}, 32'd1);
    checkOutput("bad_load_rdata", gotData, 32'd0);
    applyStimulus(1, 1'b0, 3'b010, 32'h102, 32'h0);
    checkOutput("nomis_lat", respLat, 32'd1);
    checkOutput("nomis_err", {31'b0, gotErr}, 32'd1);
    applyStimulus(1, 1'b1, 3'b010, 32'h101, 32'h12345678);
    checkOutput("nomis_store_err", {31'b0, gotErr}, 32'd1);
    checkOutput("nomis_writes", writeCount0, 32'd0);
    applyStimulus(1, 1'b0, 3'b010, 32'h104, 32'h0);
    checkOutput("nomis_aligned_lat", respLat, 32'd2);
    checkOutput("nomis_aligned_data", gotData, 32'hCAFEF00D);

    // Reset in the second byte beat of a misaligned store
    wc = writeCount;
    @(negedge clk);
    reqWe = 1'b1; funct3 = 3'b010; addr = 32'h101; wdata = 32'hAABBCCDD; reqValid = 1'b1;
    checkOutput("abort_ready", {31'b0, reqReady}, 32'd1);
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("abort_beat0_we", {31'b0, memWe}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_we_gated", {31'b0, memWe}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (respValid) pulses++;
      @(negedge clk);
    end
    checkOutput("abort_no_resp", pulses, 32'd0);
    checkOutput("abort_writes", writeCount - wc, 32'd1);
    checkOutput("abort_ready_idle", {31'b0, reqReady}, 32'd1);
    applyStimulus(0, 1'b0, 3'b010, 32'h101, 32'h0);
    checkOutput("abort_readback", gotData, 32'hA5B633DD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
